order_stage_control: RTL and testbench
======================================

// Module: order_stage_control
// PURPOSE
//  Main-control stage sequencer for the order decoders. Alternates Stage 1 (order fetch
//  into the order tank) and Stage 2 (execution), on minor-cycle boundaries. Latches
//  function bits f13..f15 from the fetched order and drives them dual-rail to the
//  order_decoder2 instances. Strobes o_dy_2 to qualify their outputs, and paces
//  execution length: short orders take one minor cycle; multiply and shift orders take
//  LONG_MC cycles. Halts on a stop order.
// PARAMETERS
//  LONG_MC   8   minor cycles of Stage 2 for long orders (>=2)
//  CNT_W     5   width of the execution minor-cycle counter (2**CNT_W > LONG_MC)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous reset, active-high
//  mc_pulse     in   1   one-clk pulse marking each minor-cycle boundary
//  run          in   1   level; 1 = sequence continuously, 0 = stop after current order
//  single_step  in   1   one-clk pulse; while halted, runs exactly one full order
//  store_ack    in   1   one-clk pulse: order word on order_in is valid
//  order_in     in   3   f15,f14,f13 of the fetched order (f15 is MSB)
//  is_long      in   1   decoder verdict: current order is multiply or shift (sampled in DECODE)
//  is_stop      in   1   decoder verdict: current order is stop (Z) (sampled in DECODE)
//  store_req    out  1   level; requests order read at the SCT address, held until store_ack
//  sct_inc      out  1   one-clk pulse; increments the sequence control tank
//  f13_pos/f13_neg, f14_pos/f14_neg, f15_pos/f15_neg   out  1 each   dual-rail order tank bits
//  o_dy_2       out  1   level; decode-valid strobe to order_decoder2 (high in DECODE and EXEC)
//  stage1       out  1   level; high in FETCH_REQ, FETCH_WAIT and DECODE
//  stage2       out  1   level; high in EXEC
//  halted       out  1   level; high in HALT
// BEHAVIOUR
//  Reset: state=HALT, counter=0, tank=000, so f*_pos=0 and f*_neg=1. store_req, sct_inc,
//   o_dy_2, stage1 and stage2 are 0; halted=1.
//  Dual rail: fN_neg == ~fN_pos at every cycle, including reset. Tank loads only on store_ack in FETCH_WAIT.
//  States and transitions (all registered; outputs are decoded from state):
//   HALT: if run, or on single_step, go to FETCH_REQ at the next mc_pulse. A step request
//    waiting for that boundary is latched in step_pend.
//   FETCH_REQ: store_req=1; go to FETCH_WAIT on the next clk.
//   FETCH_WAIT: store_req=1; on store_ack, load tank <- order_in and go to DECODE.
//    A store_ack in any other state is ignored.
//   DECODE: o_dy_2=1. Sample is_stop/is_long on the first clk.
//    If is_stop: go to HALT, clear step_pend, no sct_inc.
//    Otherwise: load cnt = is_long ? LONG_MC-1 : 0, and go to EXEC at the next mc_pulse.
//   EXEC: stage2=1, o_dy_2=1. On each mc_pulse: if cnt==0, assert sct_inc for one clk
//    and leave EXEC; otherwise decrement cnt.
//    On leaving EXEC: if run=1 and step_pend=0, go to FETCH_REQ; otherwise go to HALT
//    and clear step_pend.
//  Timing: a short order spans 1 mc_pulse in EXEC; a long order spans exactly LONG_MC.
//   sct_inc fires on the same clk the final mc_pulse is seen, once per executed order.
//  run deasserted mid-order: the current order completes; there is no abort.
//  single_step while not halted: ignored.
//  mc_pulse coincident with a state entry: it is not counted until the state is resident.
//  Reset mid-operation: immediate return to the reset values; any pending fetch is abandoned.
// TESTING
//  T1 reset: assert rst mid-EXEC -> halted=1, stage2=0, f13..f15_neg=1 on the same clk (async).
//  T2 short order: run=1, order_in=3'b101, ack 2 clk after store_req, is_long=0
//     -> f15_pos=1, f14_neg=1, f13_pos=1; stage2 for exactly 1 minor cycle; one sct_inc; refetch.
//  T3 long order: LONG_MC=8, is_long=1 -> stage2 spans 8 mc_pulses; single sct_inc on the 8th.
//  T4 stop: is_stop=1 in DECODE -> HALT, no stage2, no sct_inc, store_req stays 0 thereafter.
//  T5 single step: run=0, pulse single_step -> exactly one fetch/exec cycle, one sct_inc, halted=1.
//     A second pulse mid-order is ignored.
//  T6 run drop: run 1->0 during long EXEC -> order finishes all LONG_MC cycles, then HALT.
//     Also: store_ack injected in EXEC leaves the tank unchanged.

Source files
------------

// File: rtl/order_stage_control.sv
// order_stage_control: main-control stage sequencer for the order decoders.
// Alternates order fetch (stage 1) and execution (stage 2) on minor-cycle
// boundaries. It holds f13..f15 of the current order in a dual-rail tank,
// strobes o_dy_2 while the decoders are valid, and paces execution length.
module order_stage_control #(
  parameter int LONG_MC = 8,  // minor cycles of stage 2 for multiply/shift (>=2)
  parameter int CNT_W   = 5   // execution counter width, 2**CNT_W > LONG_MC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mc_pulse,
  input  logic       run,
  input  logic       single_step,
  input  logic       store_ack,
  input  logic [2:0] order_in,
  input  logic       is_long,
  input  logic       is_stop,
  output logic       store_req,
  output logic       sct_inc,
  output logic       f13_pos,
  output logic       f13_neg,
  output logic       f14_pos,
  output logic       f14_neg,
  output logic       f15_pos,
  output logic       f15_neg,
  output logic       o_dy_2,
  output logic       stage1,
  output logic       stage2,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_HALT,
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_DECODE,
    S_EXEC
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LONG = CNT_W'(LONG_MC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;       // remaining minor cycles of EXEC after the current one
  logic [2:0]       tank_q;      // {f15, f14, f13} of the order being executed
  logic             step_pend_q; // a single-step order is in flight or waiting to start
  logic             dec_done_q;  // decoder verdict already taken in this DECODE visit

  logic exec_last;

  // Final minor cycle of an order: EXEC sees an mc_pulse with nothing left to count.
  assign exec_last = (state_q == S_EXEC) && mc_pulse && (cnt_q == '0);

  // State sequencing, decoder sampling, execution pacing and order tank.
  // NOTE: every register here uses non-blocking assignment so all of them
  // update together from the same pre-edge values; a blocking assignment
  // would let later statements see the new value and skew the sequence.
  // NOTE: the tank is reset along with the control state because the dual-rail
  // outputs must be valid (neg = 1) while reset is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_HALT;
      cnt_q       <= '0;
      tank_q      <= '0;
      step_pend_q <= 1'b0;
      dec_done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_HALT: begin
          if (mc_pulse && (run || step_pend_q || single_step)) begin
            state_q     <= S_FETCH_REQ;
            step_pend_q <= step_pend_q | single_step;
          end else if (single_step) begin
            step_pend_q <= 1'b1;
          end
        end

        S_FETCH_REQ: state_q <= S_FETCH_WAIT;

        S_FETCH_WAIT: begin
          if (store_ack) begin
            tank_q     <= order_in;
            dec_done_q <= 1'b0;
            state_q    <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (!dec_done_q) begin
            // Decoders have had one clk to settle on the new tank contents.
            if (is_stop) begin
              state_q     <= S_HALT;
              step_pend_q <= 1'b0;
            end else begin
              cnt_q      <= is_long ? CNT_LONG : '0;
              dec_done_q <= 1'b1;
            end
          end else if (mc_pulse) begin
            state_q <= S_EXEC;
          end
        end

        S_EXEC: begin
          if (exec_last) begin
            if (run && !step_pend_q) begin
              state_q <= S_FETCH_REQ;
            end else begin
              state_q     <= S_HALT;
              step_pend_q <= 1'b0;
            end
          end else if (mc_pulse) begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        default: state_q <= S_HALT;
      endcase
    end
  end

  // Level outputs decode directly from the state register.
  assign store_req = (state_q == S_FETCH_REQ) || (state_q == S_FETCH_WAIT);
  assign stage1    = store_req || (state_q == S_DECODE);
  assign stage2    = (state_q == S_EXEC);
  assign o_dy_2    = (state_q == S_DECODE) || (state_q == S_EXEC);
  assign halted    = (state_q == S_HALT);

  // sct_inc coincides with the final mc_pulse rather than trailing it by a clk.
  assign sct_inc   = exec_last;

  assign f13_pos = tank_q[0];
  assign f13_neg = ~tank_q[0];
  assign f14_pos = tank_q[1];
  assign f14_neg = ~tank_q[1];
  assign f15_pos = tank_q[2];
  assign f15_neg = ~tank_q[2];

endmodule

// File: tb/tb_order_stage_control.sv
// Testbench for order_stage_control: directed sequence of orders through a
// store responder, with a scoreboard of expected completions (tank value and
// minor cycles spent in EXEC) checked whenever sct_inc fires.
module tb_order_stage_control;

  localparam int LONG_MC = 8;
  localparam int CNT_W   = 5;
  localparam int MC_LEN  = 4;  // clocks per minor cycle

  logic       clk = 1'b0;
  logic       rst;
  logic       mc_pulse;
  logic       run;
  logic       single_step;
  logic       store_ack;
  logic [2:0] order_in;
  logic       is_long;
  logic       is_stop;
  logic       store_req, sct_inc;
  logic       f13_pos, f13_neg, f14_pos, f14_neg, f15_pos, f15_neg;
  logic       o_dy_2, stage1, stage2, halted;

  typedef struct {
    logic [2:0] order;
    bit         lng;
    bit         stp;
  } order_t;

  typedef struct {
    logic [2:0] order;
    int         n_mc;
  } exp_t;

  order_t ord_q[$];  // words the store will return, in fetch order
  exp_t   sb_q[$];   // expected completions, in order

  int n_assert    = 0;
  int n_fail      = 0;
  int done_cnt    = 0;
  int exec_mc     = 0;
  int stage2_cyc  = 0;
  int inject_cnt  = 0;
  int inject_seen = 0;
  logic [2:0] inject_val = 3'b000;

  order_stage_control #(.LONG_MC(LONG_MC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mc_pulse(mc_pulse), .run(run),
    .single_step(single_step), .store_ack(store_ack), .order_in(order_in),
    .is_long(is_long), .is_stop(is_stop), .store_req(store_req),
    .sct_inc(sct_inc), .f13_pos(f13_pos), .f13_neg(f13_neg),
    .f14_pos(f14_pos), .f14_neg(f14_neg), .f15_pos(f15_pos),
    .f15_neg(f15_neg), .o_dy_2(o_dy_2), .stage1(stage1), .stage2(stage2),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_order(input logic [2:0] order, input bit lng, input bit stp);
    order_t o;
    exp_t   e;
    o.order = order; o.lng = lng; o.stp = stp;
    ord_q.push_back(o);
    if (!stp) begin
      e.order = order;
      e.n_mc  = lng ? LONG_MC : 1;
      sb_q.push_back(e);
    end
  endtask

  task automatic step_pulse();
    single_step = 1'b1;
    tick(1);
    single_step = 1'b0;
  endtask

  task automatic wait_stage2(input string tag);
    for (int i = 0; i < 200 && !stage2; i++) tick(1);
    check(tag, stage2, 1'b1);
  endtask

  task automatic wait_halted(input string tag);
    for (int i = 0; i < 200 && !halted; i++) tick(1);
    check(tag, halted, 1'b1);
  endtask

  task automatic wait_done(input string tag, input int n);
    for (int i = 0; i < 400 && done_cnt < n; i++) tick(1);
    check(tag, done_cnt, n);
  endtask

  // Minor-cycle boundary: one-clk pulse every MC_LEN clocks.
  initial begin
    int div = 0;
    mc_pulse = 1'b0;
    forever begin
      @(posedge clk); #1;
      mc_pulse = (div == MC_LEN - 1);
      div = (div + 1) % MC_LEN;
    end
  end

  // Store and decoder model: answers each fetch 2 clk after store_req with the
  // next queued word; also fires stray store_acks on request.
  initial begin
    order_t o;
    store_ack = 1'b0; order_in = 3'b000; is_long = 1'b0; is_stop = 1'b0;
    forever begin
      @(posedge clk); #1;
      store_ack = 1'b0;
      if (inject_cnt != inject_seen) begin
        inject_seen = inject_cnt;
        order_in    = inject_val;
        store_ack   = 1'b1;
      end else if (store_req && ord_q.size() != 0) begin
        o = ord_q.pop_front();
        repeat (2) @(posedge clk);
        #1;
        order_in  = o.order;
        is_long   = o.lng;
        is_stop   = o.stp;
        store_ack = 1'b1;
      end
    end
  end

  // Completion monitor: dual-rail integrity every cycle, scoreboard on sct_inc.
  always @(negedge clk) begin
    logic [2:0] pos_n;
    exp_t       e;
    pos_n = ~{f15_pos, f14_pos, f13_pos};
    check("dual_rail", {f15_neg, f14_neg, f13_neg}, pos_n);
    if (rst) begin
      exec_mc = 0;
    end else begin
      if (stage2) stage2_cyc++;
      if (stage2 && mc_pulse) exec_mc++;
      if (sct_inc) begin
        check("sct_inc_on_final_mc", mc_pulse & stage2, 1'b1);
        check("sct_inc_expected", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("tank_at_sct_inc", {f15_pos, f14_pos, f13_pos}, e.order);
          check("exec_minor_cycles", exec_mc, e.n_mc);
        end
        exec_mc = 0;
        done_cnt++;
      end
    end
  end

  initial begin
    int s2_before;
    logic bad;
    rst = 1'b1; run = 1'b0; single_step = 1'b0;

    // Reset values
    tick(2);
    check("rst_halted", halted, 1'b1);
    check("rst_stage1", stage1, 1'b0);
    check("rst_stage2", stage2, 1'b0);
    check("rst_store_req", store_req, 1'b0);
    check("rst_o_dy_2", o_dy_2, 1'b0);
    check("rst_sct_inc", sct_inc, 1'b0);
    check("rst_tank_neg", {f15_neg, f14_neg, f13_neg}, 3'b111);
    rst = 1'b0;
    tick(3);

    // T2 short order 101, run continuously, then refetch
    push_order(3'b101, 1'b0, 1'b0);
    run = 1'b1;
    wait_stage2("t2_stage2_reached");
    check("t2_f15_pos", f15_pos, 1'b1);
    check("t2_f14_neg", f14_neg, 1'b1);
    check("t2_f13_pos", f13_pos, 1'b1);
    check("t2_o_dy_2", o_dy_2, 1'b1);
    check("t2_stage1_low", stage1, 1'b0);
    wait_done("t2_done", 1);
    for (int i = 0; i < 20 && !store_req; i++) tick(1);
    check("t2_refetch_req", store_req, 1'b1);
    check("t2_refetch_stage1", stage1, 1'b1);

    // T3 long order 010 under run
    push_order(3'b010, 1'b1, 1'b0);
    wait_stage2("t3_stage2_reached");
    check("t3_tank", {f15_pos, f14_pos, f13_pos}, 3'b010);
    wait_done("t3_done", 2);

    // T6 run dropped mid long order; stray store_ack during EXEC
    push_order(3'b110, 1'b1, 1'b0);
    wait_stage2("t6_stage2_reached");
    tick(6);
    run = 1'b0;
    inject_val = 3'b001;
    inject_cnt++;
    tick(4);
    check("t6_tank_after_stray_ack", {f15_pos, f14_pos, f13_pos}, 3'b110);
    check("t6_still_exec", stage2, 1'b1);
    wait_done("t6_done", 3);
    wait_halted("t6_halted");
    tick(12);
    check("t6_no_refetch", store_req, 1'b0);

    // T5 single step of a long order; second pulse mid-order ignored
    push_order(3'b111, 1'b1, 1'b0);
    step_pulse();
    wait_stage2("t5_stage2_reached");
    tick(3);
    step_pulse();
    wait_done("t5_done", 4);
    wait_halted("t5_halted");
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      bad = bad | store_req | ~halted;
    end
    check("t5_stays_halted", bad, 1'b0);
    check("t5_one_sct_inc", done_cnt, 4);

    // T4 stop order fetched by single step
    s2_before = stage2_cyc;
    push_order(3'b100, 1'b0, 1'b1);
    step_pulse();
    for (int i = 0; i < 40 && !store_req; i++) tick(1);
    check("t4_fetch_req", store_req, 1'b1);
    tick(2);
    wait_halted("t4_halted");
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      bad = bad | store_req;
    end
    check("t4_no_store_req", bad, 1'b0);
    check("t4_no_stage2", stage2_cyc, s2_before);
    check("t4_no_sct_inc", done_cnt, 4);
    check("t4_tank", {f15_pos, f14_pos, f13_pos}, 3'b100);
    check("sb_drained", sb_q.size(), 0);

    // T1 asynchronous reset in the middle of EXEC
    push_order(3'b011, 1'b1, 1'b0);
    step_pulse();
    wait_stage2("t1_stage2_reached");
    tick(3);
    #3;
    rst = 1'b1;
    #1;
    check("t1_halted", halted, 1'b1);
    check("t1_stage2", stage2, 1'b0);
    check("t1_tank_neg", {f15_neg, f14_neg, f13_neg}, 3'b111);
    check("t1_o_dy_2", o_dy_2, 1'b0);
    sb_q.delete();
    tick(2);
    rst = 1'b0;
    tick(10);
    check("t1_idle_after_reset", {halted, store_req, stage2}, 3'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
